// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: bundles both requester ports, the shared read-return bus
// and the register file drive lines of regfile_arbiter.
// slave  : the arbiter side.
// master : the requesters plus the register file (testbench / surrounding logic).
interface regfile_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_rs;
  logic [ADDR_W-1:0] req0_rt;
  logic [ADDR_W-1:0] req0_rd;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_rs;
  logic [ADDR_W-1:0] req1_rt;
  logic [ADDR_W-1:0] req1_rd;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_rs_data;
  logic [DATA_W-1:0] rsp_rt_data;

  logic              rf_write;
  logic [ADDR_W-1:0] rf_rs_addr;
  logic [ADDR_W-1:0] rf_rt_addr;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_data;
  logic [DATA_W-1:0] rf_rs_data;
  logic [DATA_W-1:0] rf_rt_data;

  modport slave (
    input  req0_valid, req0_write, req0_rs, req0_rt, req0_rd, req0_data,
    input  req1_valid, req1_write, req1_rs, req1_rt, req1_rd, req1_data,
    input  rf_rs_data, rf_rt_data,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_rs_data, rsp_rt_data,
    output rf_write, rf_rs_addr, rf_rt_addr, rf_rd_addr, rf_data
  );

  modport master (
    output req0_valid, req0_write, req0_rs, req0_rt, req0_rd, req0_data,
    output req1_valid, req1_write, req1_rs, req1_rt, req1_rd, req1_data,
    output rf_rs_data, rf_rt_data,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_rs_data, rsp_rt_data,
    input  rf_write, rf_rs_addr, rf_rt_addr, rf_rd_addr, rf_data
  );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares a single-ported 8x16 register file (one write or one
// dual read per clock) between port 0 (execute/writeback) and port 1
// (debug/load) with round-robin fairness. Read data returns one cycle after
// the grant on a shared bus, tagged by rsp0_valid / rsp1_valid.
// Optional feature macro: REGFILE_ARB_STATS_EN adds saturating grant and
// conflict counters with a synchronous clear.
module regfile_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic        clock,
  input  logic        reset_n,
`ifdef REGFILE_ARB_STATS_EN
  input  logic        stat_clear,
  output logic [15:0] stat_grant0,
  output logic [15:0] stat_grant1,
  output logic [15:0] stat_conflict,
`endif
  regfile_arbiter_if.slave bus
);

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  logic              prio_q, prio_d;
  logic              rsp0_q, rsp0_d;
  logic              rsp1_q, rsp1_d;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              grant0_s, grant1_s, grant_s, gnt_write_s;
  logic [ADDR_W-1:0] gnt_rs_s, gnt_rt_s, gnt_rd_s;
  logic [DATA_W-1:0] gnt_data_s;

  // Grant: a lone requester wins outright; on contention prio_q picks the winner.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!reset_n) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (bus.req0_valid && bus.req1_valid) begin
      grant0_s = (prio_q == PORT0);
      grant1_s = (prio_q == PORT1);
    end else begin
      grant0_s = bus.req0_valid;
      grant1_s = bus.req1_valid;
    end
  end

  // Select the fields of whichever port won this cycle.
  always_comb begin
    grant_s = grant0_s | grant1_s;
    if (grant1_s) begin
      gnt_write_s = bus.req1_write;
      gnt_rs_s    = bus.req1_rs;
      gnt_rt_s    = bus.req1_rt;
      gnt_rd_s    = bus.req1_rd;
      gnt_data_s  = bus.req1_data;
    end else begin
      gnt_write_s = grant0_s & bus.req0_write;
      gnt_rs_s    = bus.req0_rs;
      gnt_rt_s    = bus.req0_rt;
      gnt_rd_s    = bus.req0_rd;
      gnt_data_s  = bus.req0_data;
    end
  end

  // Next state: hand priority to the loser, tag a read response, hold rf drive.
  always_comb begin
    prio_d    = prio_q;
    rsp0_d    = 1'b0;
    rsp1_d    = 1'b0;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    if (grant_s) begin
      prio_d = grant0_s ? PORT1 : PORT0;
      if (gnt_write_s) begin
        rd_addr_d = gnt_rd_s;
        data_d    = gnt_data_s;
      end else begin
        rs_addr_d = gnt_rs_s;
        rt_addr_d = gnt_rt_s;
        rsp0_d    = grant0_s;
        rsp1_d    = grant1_s;
      end
    end else begin
      prio_d = prio_q;
    end
  end

  // State registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prio_q    <= PORT0;
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
      rs_addr_q <= {ADDR_W{1'b0}};
      rt_addr_q <= {ADDR_W{1'b0}};
      rd_addr_q <= {ADDR_W{1'b0}};
      data_q    <= {DATA_W{1'b0}};
    end else begin
      prio_q    <= prio_d;
      rsp0_q    <= rsp0_d;
      rsp1_q    <= rsp1_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
    end
  end

  // Drive the register file and the response bus; idle cycles re-read the held addresses.
  always_comb begin
    bus.req0_ready  = grant0_s;
    bus.req1_ready  = grant1_s;
    bus.rf_write    = gnt_write_s;
    bus.rsp0_valid  = rsp0_q & reset_n;
    bus.rsp1_valid  = rsp1_q & reset_n;
    bus.rsp_rs_data = bus.rf_rs_data;
    bus.rsp_rt_data = bus.rf_rt_data;
    bus.rf_rs_addr  = rs_addr_q;
    bus.rf_rt_addr  = rt_addr_q;
    bus.rf_rd_addr  = rd_addr_q;
    bus.rf_data     = data_q;
    if (!reset_n) begin
      bus.rf_rs_addr = {ADDR_W{1'b0}};
      bus.rf_rt_addr = {ADDR_W{1'b0}};
      bus.rf_rd_addr = {ADDR_W{1'b0}};
      bus.rf_data    = {DATA_W{1'b0}};
    end else if (gnt_write_s) begin
      bus.rf_rd_addr = gnt_rd_s;
      bus.rf_data    = gnt_data_s;
    end else if (grant_s) begin
      bus.rf_rs_addr = gnt_rs_s;
      bus.rf_rt_addr = gnt_rt_s;
    end else begin
      bus.rf_rs_addr = rs_addr_q;
      bus.rf_rt_addr = rt_addr_q;
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] grant0_cnt_q, grant0_cnt_d;
  logic [15:0] grant1_cnt_q, grant1_cnt_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        conflict_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
    if (en && (value != 16'hFFFF)) begin
      return value + 16'd1;
    end else begin
      return value;
    end
  endfunction

  // Counter next state: clear beats any increment, counts stick at all-ones.
  always_comb begin
    conflict_s = reset_n & bus.req0_valid & bus.req1_valid;
    if (stat_clear) begin
      grant0_cnt_d   = 16'd0;
      grant1_cnt_d   = 16'd0;
      conflict_cnt_d = 16'd0;
    end else begin
      grant0_cnt_d   = sat_inc(grant0_cnt_q, grant0_s);
      grant1_cnt_d   = sat_inc(grant1_cnt_q, grant1_s);
      conflict_cnt_d = sat_inc(conflict_cnt_q, conflict_s);
    end
  end

  // Statistics registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      grant0_cnt_q   <= 16'd0;
      grant1_cnt_q   <= 16'd0;
      conflict_cnt_q <= 16'd0;
    end else begin
      grant0_cnt_q   <= grant0_cnt_d;
      grant1_cnt_q   <= grant1_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign stat_grant0   = grant0_cnt_q;
  assign stat_grant1   = grant1_cnt_q;
  assign stat_conflict = conflict_cnt_q;
`endif

endmodule
